// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the round-robin multiplier-sharing arbiter.
package mul_share_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wrapping increment of a requester index modulo n.
  function automatic int unsigned rr_next(input int unsigned last, input int unsigned n);
    return (last + 1 >= n) ? 0 : last + 1;
  endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module rr_picker
  import mul_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  winner,
  output logic             any_valid
);

  logic [ID_W-1:0] cand;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = last_grant;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'(rr_next(32'(cand), N_REQ));
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one external combinational multiplier among N_REQ
// requesters; one operation in flight, response tagged with the owner's index.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [W-1:0]       mul_result,
  output logic               rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  input  logic               rsp_ready,
  output logic               busy,
  output logic [7:0]         op_count
);

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [ID_W-1:0] winner;
  logic            any_valid;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // Gated by rst_n so the accept strobe is silent while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && any_valid) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign mul_a = op_a;
  assign mul_b = op_b;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      op_count   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            op_a       <= req_a[int'(winner)*W +: W];
            op_b       <= req_b[int'(winner)*W +: W];
            last_grant <= winner;
            state      <= BUSY;
          end
        end
        BUSY: begin
          rsp_data  <= mul_result;
          rsp_id    <= last_grant;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: stimulus pushes expected responses, a monitor pops and compares.
module tb_mul_share_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 4;
  localparam int ID_W  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [N_REQ*W-1:0] req_a = '0;
  logic [N_REQ*W-1:0] req_b = '0;
  logic [N_REQ-1:0]   req_ready;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic [W-1:0]       mul_result;
  logic               rsp_valid;
  logic [W-1:0]       rsp_data;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_ready = 1'b1;
  logic               busy;
  logic [7:0]         op_count;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [W-1:0]    data;
  } exp_t;

  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   exp_ops      = 0;
  int   cyc          = 0;
  int   last_acc_cyc = 0;

  mul_share_arbiter #(.N_REQ(N_REQ), .W(W), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Stand-in for the parent's truncating multiplier.
  assign mul_result = 4'(mul_a * mul_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on every response handshake and checks hold stability while stalled.
  initial begin
    logic            hold_v;
    logic [W-1:0]    hold_d;
    logic [ID_W-1:0] hold_id;
    exp_t            e;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          check("rsp_hold_data", 32'(rsp_data), 32'(hold_d));
          check("rsp_hold_id", 32'(rsp_id), 32'(hold_id));
        end
        hold_v = 1'b0;
        if (rsp_valid) begin
          if (rsp_ready) begin
            if (sb.size() == 0) begin
              n_compared++;
              n_mismatched++;
              $display("[TB] FAIL unexpected_rsp: got id=%0d data=%0h, scoreboard empty", rsp_id, rsp_data);
            end else begin
              e = sb.pop_front();
              check("rsp_data", 32'(rsp_data), 32'(e.data));
              check("rsp_id", 32'(rsp_id), 32'(e.id));
            end
            exp_ops++;
          end else begin
            hold_v  = 1'b1;
            hold_d  = rsp_data;
            hold_id = rsp_id;
          end
        end
      end
    end
  end

  task automatic wait_accept(input int id, input logic [W-1:0] exp_data, input bit push, input bit drop);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (req_ready == '0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (req_ready == '0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL accept_timeout: req_ready stayed 0, wanted grant to %0d", id);
    end else begin
      check("req_ready_grant", 32'(req_ready), 32'(1 << id));
      last_acc_cyc = cyc;
      if (push) begin
        e.id   = ID_W'(id);
        e.data = exp_data;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (drop) req_valid[id] = 1'b0;
  endtask

  task automatic issue_one(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_data, input bit push);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id]    = 1'b1;
    wait_accept(id, exp_data, push, 1'b1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || busy) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, busy=%0b", sb.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order [5];
    int prev;
    logic [W-1:0] exp_rr [4];
    order  = '{0, 1, 2, 3, 0};
    exp_rr = '{4'd6, 4'd4, 4'd1, 4'd10};
    prev   = 0;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    exp_ops = 0;

    $display("[TB] single request from requester 1");
    issue_one(1, 4'd3, 4'd5, 4'd15, 1'b1);
    @(negedge clk);
    check("busy_phase_busy", 32'(busy), 32'd1);
    check("busy_phase_req_ready", 32'(req_ready), 32'd0);
    check("busy_phase_rsp_valid", 32'(rsp_valid), 32'd0);
    check("busy_phase_mul_a", 32'(mul_a), 32'd3);
    check("busy_phase_mul_b", 32'(mul_b), 32'd5);
    @(negedge clk);
    check("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_drain();
    check("op_count_after_1", 32'(op_count), 32'd1);

    $display("[TB] truncated product from requester 2");
    issue_one(2, 4'd7, 4'd6, 4'd10, 1'b1);
    wait_drain();
    check("op_count_after_2", 32'(op_count), 32'd2);

    $display("[TB] all requesters valid from reset");
    rst_n = 1'b0;
    req_a = {4'd6, 4'd9, 4'd4, 4'd2};
    req_b = {4'd7, 4'd9, 4'd5, 4'd3};
    req_valid = 4'hF;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    exp_ops = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept(order[k], exp_rr[order[k]], 1'b1, (k == 4));
      if (k > 0) check("accept_spacing", 32'(last_acc_cyc - prev), 32'd3);
      prev = last_acc_cyc;
    end
    req_valid = '0;
    wait_drain();
    check("op_count_rr", 32'(op_count), 32'd5);

    $display("[TB] stalled response");
    rsp_ready = 1'b0;
    issue_one(1, 4'd5, 4'd3, 4'd15, 1'b1);
    req_a[3:0] = 4'd1;
    req_b[3:0] = 4'd1;
    req_valid[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("handshake_cycle_req_ready", 32'(req_ready), 32'd0);
    wait_accept(0, 4'd1, 1'b1, 1'b1);
    check("op_count_single_completion", 32'(op_count), 32'd6);
    wait_drain();
    check("op_count_after_stall", 32'(op_count), 32'(exp_ops));

    $display("[TB] reset while busy");
    issue_one(0, 4'd2, 4'd2, 4'd4, 1'b0);
    #2 rst_n = 1'b0;
    req_a[7:0] = {4'd2, 4'd3};
    req_b[7:0] = {4'd7, 4'd3};
    req_valid  = 4'b0011;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_mul_a", 32'(mul_a), 32'd0);
    check("midrst_mul_b", 32'(mul_b), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_ops = 0;
    wait_accept(0, 4'd9, 1'b1, 1'b1);
    wait_accept(1, 4'd14, 1'b1, 1'b1);
    wait_drain();
    check("op_count_post_reset", 32'(op_count), 32'd2);

    $display("[TB] 256 operations from requester 3");
    rst_n = 1'b0;
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    exp_ops = 0;
    for (int k = 0; k < 256; k++) begin
      issue_one(3, 4'(k), 4'd3, 4'((k * 3) & 15), 1'b1);
    end
    wait_drain();
    check("op_count_wrap", 32'(op_count), 32'd0);
    check("handshakes_seen", 32'(exp_ops), 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one combinational 4-bit multiplier (result truncated to 4 bits) among N_REQ requesters.
- Arbitrates with round-robin priority and latches the granted operands, which drive the multiplier.
- Captures the product and returns it on a single response channel tagged with the requester ID.
- Sits between the lab's operand sources (switch/FSM front-ends) and the multiplier instance in the parent.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 4, operand/result width; must match the multiplier.
- ID_W, 2, width of requester ID; equals $clog2(N_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_a  input  N_REQ*W  packed operand A; requester i occupies bits [i*W +: W].
- req_b  input  N_REQ*W  packed operand B; same packing as req_a.
- req_ready  output  N_REQ  one-hot accept strobe; all-zero when nothing is accepted.
- mul_a  output  W  operand A to the multiplier.
- mul_b  output  W  operand B to the multiplier.
- mul_result  input  W  multiplier result, combinational from mul_a/mul_b.
- rsp_valid  output  1  response valid.
- rsp_data  output  W  product bits [W-1:0].
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_ready  input  1  response consumer ready.
- busy  output  1  high whenever state != IDLE.
- op_count  output  8  completed-operation counter; wraps 255->0.

Behaviour:
- Reset values (async, while rst_n=0):
  - state=IDLE; rsp_valid=0; rsp_data=0; rsp_id=0.
  - Operand registers=0, so mul_a=mul_b=0.
  - last_grant=N_REQ-1, so requester 0 wins first; op_count=0; busy=0; req_ready=0.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching last_grant+1 upward and wrapping modulo N_REQ.
  - If any requester is valid: req_ready[winner]=1 combinationally in the same cycle.
  - At that clock edge: latch req_a/req_b slice of the winner into operand regs, set last_grant=winner, go to BUSY.
  - If none is valid: req_ready=0 and state is held.
- BUSY (exactly 1 cycle):
  - mul_a/mul_b are driven from the operand regs.
  - At the edge: rsp_data<=mul_result, rsp_id<=last_grant, rsp_valid<=1, go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_valid && rsp_ready at a clock edge.
  - On that edge: rsp_valid<=0, op_count<=op_count+1, go to IDLE.
- req_ready is 0 in BUSY and RESP. No new request is accepted until the cycle after the response handshake.
- Timing:
  - Accept edge to rsp_valid high: 2 cycles.
  - Minimum spacing between accepts: 3 cycles.
- Arithmetic: product = (A*B) mod 2^W, as supplied by the multiplier. The arbiter does no arithmetic on the data; only op_count increments.
- Requester rules:
  - A requester holds req_valid and its operands until it sees req_ready.
  - The arbiter never grants a requester whose req_valid=0.
- Simultaneous events:
  - req_valid arriving in RESP in the same cycle as the response handshake is not accepted that cycle; it is arbitrated in the following IDLE cycle.
- Reset mid-operation: everything returns to reset values immediately. Any in-flight response is discarded, and op_count does not count it.
- Illegal/unused state encodings recover to IDLE.

Decomposition:
- Package mul_share_pkg:
  - state enum state_t {IDLE, BUSY, RESP}.
  - Default constants N_REQ_DEF=4, W_DEF=4.
  - Function rr_next(last, n) for the wrap increment.
- Sub-module rr_picker (combinational):
  - Inputs: req_valid vector, last_grant.
  - Outputs: winner index, any_valid.
- The multiplier is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then requester 1 requests a=3, b=5 -> req_ready=0010 for 1 cycle; 2 cycles later rsp_valid=1, rsp_data=15, rsp_id=1; op_count=1 after the handshake.
- Requester 2 requests a=7, b=6 -> rsp_data=10 (42 mod 16), rsp_id=2.
- All four requesters valid continuously from reset, rsp_ready=1 -> grant order 0,1,2,3,0; accepts exactly 3 cycles apart.
- rsp_ready=0 for 5 cycles during RESP -> rsp_valid/rsp_data/rsp_id stable; req_ready stays 0 throughout; single completion counted.
- Assert rst_n=0 while in BUSY -> all outputs reach reset values asynchronously; after release, op_count=0 and the next grant goes to requester 0.
- 256 back-to-back operations from requester 3 only -> every response has rsp_id=3; op_count wraps to 0.
